// File: rtl/axi_inf_read_state_core_if.sv
// AXI4 read-address and read-data channels between the read-burst core and the memory port.
interface axi_inf_read_state_core_if #(
    parameter int IDSIZE = 4,
    parameter int LSIZE  = 9,
    parameter int ASIZE  = 29,
    parameter int DSIZE  = 256
);
    logic [IDSIZE-1:0] axi_arid;
    logic [ASIZE-1:0]  axi_araddr;
    logic [LSIZE-1:0]  axi_arlen;
    logic [2:0]        axi_arsize;
    logic [1:0]        axi_arburst;
    logic              axi_arlock;
    logic [3:0]        axi_arcache;
    logic [2:0]        axi_arprot;
    logic [3:0]        axi_arqos;
    logic              axi_arvalid;
    logic              axi_arready;
    logic [IDSIZE-1:0] axi_rid;
    logic [DSIZE-1:0]  axi_rdata;
    logic [1:0]        axi_rresp;
    logic              axi_rlast;
    logic              axi_rvalid;
    logic              axi_rready;

    modport master (
        output axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst, axi_arlock,
               axi_arcache, axi_arprot, axi_arqos, axi_arvalid, axi_rready,
        input  axi_arready, axi_rid, axi_rdata, axi_rresp, axi_rlast, axi_rvalid
    );

    modport slave (
        input  axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst, axi_arlock,
               axi_arcache, axi_arprot, axi_arqos, axi_arvalid, axi_rready,
        output axi_arready, axi_rid, axi_rdata, axi_rresp, axi_rlast, axi_rvalid
    );
endinterface

// File: rtl/axi_inf_read_state_core.sv
// Single-outstanding AXI4 read-burst engine: one AR per request, R beats forwarded to a FIFO,
// with burst-length / response checking and pend-chain serialisation against sibling masters.
module axi_inf_read_state_core #(
    parameter int IDSIZE = 4,
    parameter int ID     = 0,
    parameter int LSIZE  = 9,
    parameter int ASIZE  = 29,
    parameter int DSIZE  = 256
) (
    input  logic                 axi_aclk,
    input  logic                 axi_resetn,
    input  logic                 read_req,
    input  logic [LSIZE-1:0]     req_len,
    input  logic [ASIZE-1:0]     req_addr,
    output logic                 req_resp,
    output logic                 req_done,
    input  logic                 pend_in,
    output logic                 pend_out,
    axi_inf_read_state_core_if.master axi,
    input  logic                 fifo_almost_full,
    output logic [DSIZE-1:0]     odata,
    output logic                 odata_vld,
    output logic                 len_err,
    output logic                 resp_err
);
    localparam logic [2:0] AR_SIZE = 3'($clog2(DSIZE / 8));

    typedef enum logic [2:0] {IDLE, ADDR, DATA, DRAIN, DONE} state_t;

    state_t            state;
    logic              arvalid;
    logic [ASIZE-1:0]  araddr;
    logic [LSIZE-1:0]  arlen;
    logic [LSIZE-1:0]  cnt;
    logic              r_hs;
    logic              last_beat;

    assign axi.axi_arid    = IDSIZE'(ID);
    assign axi.axi_araddr  = araddr;
    assign axi.axi_arlen   = arlen;
    assign axi.axi_arsize  = AR_SIZE;
    assign axi.axi_arburst = 2'b01;
    assign axi.axi_arlock  = 1'b0;
    assign axi.axi_arcache = 4'b0011;
    assign axi.axi_arprot  = 3'b000;
    assign axi.axi_arqos   = 4'b0000;
    assign axi.axi_arvalid = arvalid;

    // DRAIN discards surplus beats, so it must not stall on the FIFO.
    assign axi.axi_rready = ((state == DATA) && !fifo_almost_full) || (state == DRAIN);
    assign r_hs           = axi.axi_rvalid && axi.axi_rready;
    assign last_beat      = (cnt == arlen);
    assign pend_out       = (state != IDLE);

    always_ff @(posedge axi_aclk) begin
        if (!axi_resetn) begin
            state     <= IDLE;
            arvalid   <= 1'b0;
            araddr    <= '0;
            arlen     <= '0;
            cnt       <= '0;
            odata     <= '0;
            odata_vld <= 1'b0;
            req_resp  <= 1'b0;
            req_done  <= 1'b0;
            len_err   <= 1'b0;
            resp_err  <= 1'b0;
        end else begin
            req_resp  <= 1'b0;
            req_done  <= 1'b0;
            odata_vld <= 1'b0;
            len_err   <= 1'b0;
            resp_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (read_req && !pend_in) begin
                        req_resp <= 1'b1;
                        // A zero-length request completes on the spot without touching the bus.
                        if (req_len == '0) begin
                            req_done <= 1'b1;
                        end else begin
                            araddr  <= req_addr;
                            arlen   <= req_len - 1'b1;
                            arvalid <= 1'b1;
                            state   <= ADDR;
                        end
                    end
                end
                ADDR: begin
                    if (axi.axi_arready) begin
                        arvalid <= 1'b0;
                        cnt     <= '0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (r_hs) begin
                        odata     <= axi.axi_rdata;
                        odata_vld <= 1'b1;
                        cnt       <= cnt + 1'b1;
                        resp_err  <= (axi.axi_rresp != 2'b00);
                        if (axi.axi_rlast) begin
                            len_err  <= !last_beat;
                            req_done <= 1'b1;
                            state    <= DONE;
                        end else if (last_beat) begin
                            len_err <= 1'b1;
                            state   <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (r_hs) begin
                        resp_err <= (axi.axi_rresp != 2'b00);
                        if (axi.axi_rlast) begin
                            req_done <= 1'b1;
                            state    <= DONE;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_inf_read_state_core.sv
// Directed bench for axi_inf_read_state_core: a bench-side slave plus a beat-level scoreboard.
module tb_axi_inf_read_state_core;
    localparam int IDSIZE = 4;
    localparam int LSIZE  = 9;
    localparam int ASIZE  = 29;
    localparam int DSIZE  = 256;

    logic              clk;
    logic              axi_resetn;
    logic              read_req;
    logic [LSIZE-1:0]  req_len;
    logic [ASIZE-1:0]  req_addr;
    logic              req_resp;
    logic              req_done;
    logic              pend_in;
    logic              pend_out;
    logic              fifo_almost_full;
    logic [DSIZE-1:0]  odata;
    logic              odata_vld;
    logic              len_err;
    logic              resp_err;

    axi_inf_read_state_core_if #(.IDSIZE(IDSIZE), .LSIZE(LSIZE), .ASIZE(ASIZE), .DSIZE(DSIZE)) axi ();

    axi_inf_read_state_core #(
        .IDSIZE(IDSIZE), .ID(0), .LSIZE(LSIZE), .ASIZE(ASIZE), .DSIZE(DSIZE)
    ) dut (
        .axi_aclk(clk), .axi_resetn(axi_resetn),
        .read_req(read_req), .req_len(req_len), .req_addr(req_addr),
        .req_resp(req_resp), .req_done(req_done),
        .pend_in(pend_in), .pend_out(pend_out),
        .axi(axi),
        .fifo_almost_full(fifo_almost_full),
        .odata(odata), .odata_vld(odata_vld), .len_err(len_err), .resp_err(resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Expected pulses for the current cycle, plus the forwarded-beat queue.
    logic exp_vld, exp_resp, exp_done, exp_len_err, exp_resp_err, busy;
    logic [DSIZE-1:0] exp_q[$];
    int n_vld, n_done, n_lerr, n_rerr;
    int tag;

    task automatic chk(input string name, input logic [DSIZE-1:0] act, input logic [DSIZE-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DSIZE-1:0] beat_data(input int t, input int i);
        logic [15:0] th, il;
        th = t[15:0];
        il = i[15:0];
        return {8{th, il}};
    endfunction

    // Per-cycle comparison against the expected pulses, run at the falling edge.
    task automatic at_neg();
        @(negedge clk);
        chk("odata_vld", odata_vld, exp_vld);
        if (odata_vld) begin
            if (exp_q.size() == 0) chk("odata_unexpected", odata_vld, 1'b0);
            else chk("odata", odata, exp_q.pop_front());
        end
        chk("req_resp", req_resp, exp_resp);
        chk("req_done", req_done, exp_done);
        chk("len_err", len_err, exp_len_err);
        chk("resp_err", resp_err, exp_resp_err);
        chk("pend_out", pend_out, busy);
        if (odata_vld) n_vld++;
        if (req_done)  n_done++;
        if (len_err)   n_lerr++;
        if (resp_err)  n_rerr++;
        exp_vld = 0; exp_resp = 0; exp_done = 0; exp_len_err = 0; exp_resp_err = 0;
    endtask

    task automatic at_pos();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_counts();
        n_vld = 0; n_done = 0; n_lerr = 0; n_rerr = 0;
        tag++;
    endtask

    task automatic issue_req(input logic [ASIZE-1:0] addr, input int len, input int pend_cycles);
        read_req = 1'b1;
        req_addr = addr;
        req_len  = LSIZE'(len);
        pend_in  = (pend_cycles > 0);
        for (int k = 0; k < pend_cycles; k++) begin
            at_neg();
            chk("arvalid_blocked", axi.axi_arvalid, 1'b0);
            at_pos();
        end
        pend_in = 1'b0;
        at_neg();
        at_pos();
        read_req = 1'b0;
        exp_resp = 1'b1;
        if (len == 0) exp_done = 1'b1;
        else busy = 1'b1;
    endtask

    task automatic serve(input logic [ASIZE-1:0] addr, input int len, input int nbeats,
                         input int af_lo, input int af_hi, input int err_beat,
                         input int ar_delay, input int abort_at);
        int  i, cyc;
        logic stall, hs, exp_rr;
        axi.axi_arready = 1'b0;
        for (int d = 0; d <= ar_delay; d++) begin
            if (d == ar_delay) axi.axi_arready = 1'b1;
            at_neg();
            chk("arvalid", axi.axi_arvalid, 1'b1);
            chk("araddr", axi.axi_araddr, addr);
            chk("arlen", axi.axi_arlen, LSIZE'(len - 1));
            at_pos();
        end
        axi.axi_arready = 1'b0;
        i = 0; cyc = 0; stall = 1'b0;
        while (i < nbeats && cyc < 200) begin
            axi.axi_rvalid   = 1'b1;
            axi.axi_rdata    = beat_data(tag, i);
            axi.axi_rlast    = (i == nbeats - 1);
            axi.axi_rresp    = (i == err_beat) ? 2'b10 : 2'b00;
            fifo_almost_full = (i >= af_lo) && (i <= af_hi) && !stall;
            at_neg();
            exp_rr = (i >= len) ? 1'b1 : !fifo_almost_full;
            chk("rready", axi.axi_rready, exp_rr);
            hs = exp_rr;
            at_pos();
            if (hs) begin
                if (i < len) begin
                    exp_q.push_back(beat_data(tag, i));
                    exp_vld = 1'b1;
                end
                if ((i == nbeats - 1 && i < len - 1) || (i == len - 1 && i != nbeats - 1))
                    exp_len_err = 1'b1;
                if (i == err_beat) exp_resp_err = 1'b1;
                if (i == nbeats - 1) exp_done = 1'b1;
                i++;
                stall = 1'b0;
            end else begin
                stall = 1'b1;
            end
            cyc++;
            if (i == abort_at) break;
        end
        fifo_almost_full = 1'b0;
        if (i == abort_at) begin
            axi_resetn = 1'b0;
            at_neg();
            at_pos();
            busy = 1'b0;
            exp_q.delete();
            axi.axi_rvalid = 1'b0;
            axi.axi_rlast  = 1'b0;
            at_neg();
            chk("rst_arvalid", axi.axi_arvalid, 1'b0);
            chk("rst_rready", axi.axi_rready, 1'b0);
            chk("rst_odata", odata, '0);
            chk("rst_araddr", axi.axi_araddr, '0);
            chk("rst_arlen", axi.axi_arlen, '0);
            at_pos();
            axi_resetn = 1'b1;
        end else begin
            chk("r_beats_served", i, nbeats);
            axi.axi_rvalid = 1'b0;
            axi.axi_rlast  = 1'b0;
            at_neg();
            at_pos();
            busy = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        axi_resetn = 1'b0; read_req = 1'b0; req_len = '0; req_addr = '0; pend_in = 1'b0;
        fifo_almost_full = 1'b0;
        axi.axi_arready = 1'b0; axi.axi_rid = '0; axi.axi_rdata = '0; axi.axi_rresp = 2'b00;
        axi.axi_rlast = 1'b0; axi.axi_rvalid = 1'b0;
        exp_vld = 0; exp_resp = 0; exp_done = 0; exp_len_err = 0; exp_resp_err = 0; busy = 0;
        tag = 0;
        clear_counts();

        at_pos();
        at_neg();
        chk("rst_arvalid0", axi.axi_arvalid, 1'b0);
        chk("rst_rready0", axi.axi_rready, 1'b0);
        chk("rst_odata0", odata, '0);
        chk("rst_araddr0", axi.axi_araddr, '0);
        chk("rst_arlen0", axi.axi_arlen, '0);
        chk("arsize", axi.axi_arsize, 3'd5);
        chk("arburst", axi.axi_arburst, 2'b01);
        chk("arcache", axi.axi_arcache, 4'b0011);
        chk("arid", axi.axi_arid, 4'd0);
        chk("arlock_prot_qos", {axi.axi_arlock, axi.axi_arprot, axi.axi_arqos}, '0);
        at_pos();
        axi_resetn = 1'b1;

        // Normal 16-beat burst
        clear_counts();
        issue_req(29'h100, 16, 0);
        serve(29'h100, 16, 16, -1, -1, -1, 0, -1);
        chk("normal_vld_count", n_vld, 16);
        chk("normal_done_count", n_done, 1);
        chk("normal_len_err", n_lerr, 0);
        chk("normal_arlen_lit", axi.axi_arlen, 9'd15);
        chk("normal_araddr_lit", axi.axi_araddr, 29'h100);

        // Backpressure on beats 3-5, slow AR acceptance
        clear_counts();
        issue_req(29'h2000, 8, 0);
        serve(29'h2000, 8, 8, 2, 4, -1, 2, -1);
        chk("bp_vld_count", n_vld, 8);
        chk("bp_done_count", n_done, 1);

        // Early rlast on beat 4
        clear_counts();
        issue_req(29'h300, 8, 0);
        serve(29'h300, 8, 4, -1, -1, -1, 0, -1);
        chk("early_vld_count", n_vld, 4);
        chk("early_len_err", n_lerr, 1);
        chk("early_done_count", n_done, 1);

        // Late rlast: 6 beats for a 4-beat request; backpressure ignored while draining
        clear_counts();
        issue_req(29'h400, 4, 0);
        serve(29'h400, 4, 6, 4, 5, -1, 0, -1);
        chk("late_vld_count", n_vld, 4);
        chk("late_len_err", n_lerr, 1);
        chk("late_done_count", n_done, 1);

        // Sibling busy for 10 cycles
        clear_counts();
        issue_req(29'h500, 2, 10);
        serve(29'h500, 2, 2, -1, -1, -1, 0, -1);
        chk("arb_vld_count", n_vld, 2);

        // Zero-length request
        clear_counts();
        issue_req(29'h40, 0, 0);
        at_neg();
        chk("zero_no_ar", axi.axi_arvalid, 1'b0);
        at_pos();
        at_neg();
        at_pos();
        chk("zero_done_count", n_done, 1);
        chk("zero_vld_count", n_vld, 0);

        // Error response on beat 2
        clear_counts();
        issue_req(29'h600, 4, 0);
        serve(29'h600, 4, 4, -1, -1, 1, 0, -1);
        chk("rerr_count", n_rerr, 1);
        chk("rerr_vld_count", n_vld, 4);

        // Reset in the middle of DATA
        clear_counts();
        issue_req(29'h700, 8, 0);
        serve(29'h700, 8, 8, -1, -1, -1, 0, 3);
        chk("abort_done_count", n_done, 0);
        chk("abort_vld_count", n_vld, 3);

        // Recovery after reset
        clear_counts();
        issue_req(29'h800, 1, 0);
        serve(29'h800, 1, 1, -1, -1, -1, 0, -1);
        chk("recover_vld_count", n_vld, 1);
        chk("recover_done_count", n_done, 1);
        at_neg();
        at_pos();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
